// File: rtl/btn_pkg.sv
// Shared encodings and default timing for the button event decoder.
// State codes are 3-bit so they fit a compact one-register FSM.
package btn_pkg;

   localparam int unsigned DEF_CNT_W  = 24;
   localparam int unsigned DEF_LONG   = 12_000_000;
   localparam int unsigned DEF_DCLICK = 3_000_000;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_PRESS1 = 3'd1;
   localparam state_t S_LONG   = 3'd2;
   localparam state_t S_WAIT2  = 3'd3;
   localparam state_t S_PRESS2 = 3'd4;

endpackage

// File: rtl/button_events_if.sv
// Button level in, event strobes and held level out.
// slave is the decoder side, master is the button/consumer side.
interface button_events_if;

   logic clean_in;
   logic press_pulse;
   logic release_pulse;
   logic short_click;
   logic double_click;
   logic long_press;
   logic held;

   modport slave (
      input  clean_in,
      output press_pulse,
      output release_pulse,
      output short_click,
      output double_click,
      output long_press,
      output held
   );

   modport master (
      output clean_in,
      input  press_pulse,
      input  release_pulse,
      input  short_click,
      input  double_click,
      input  long_press,
      input  held
   );

endinterface

// File: rtl/button_events_edge_det.sv
// Rise/fall detector on the clean button level, plus the held copy.
// prev follows the input even in reset so a held button is not a press.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall,
   output logic held
);

   logic prev;

   always_ff @(posedge clk) begin
      prev <= d;
      if (rst) begin
         held <= 1'b0;
      end else begin
         held <= d;
      end
   end

   assign rise = d & ~prev;
   assign fall = ~d & prev;

endmodule

// File: rtl/button_events.sv
// Click / double-click / long-press decoder with a saturating timer.
// All strobes are registered and last exactly one cycle.
module button_events
   import btn_pkg::*;
#(
   parameter int unsigned CNT_W         = DEF_CNT_W,
   parameter int unsigned LONG_CYCLES   = DEF_LONG,
   parameter int unsigned DCLICK_CYCLES = DEF_DCLICK
) (
   input  logic             clk,
   input  logic             rst,
   button_events_if.slave   bus
);

   localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DCLK_END = CNT_W'(DCLICK_CYCLES - 1);

   logic             rise;
   logic             fall;
   logic             held_q;
   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] timer_nx;
   logic [CNT_W-1:0] timer_inc;
   logic             short_nx;
   logic             dbl_nx;
   logic             long_nx;
   logic             press_q;
   logic             release_q;
   logic             short_q;
   logic             dbl_q;
   logic             long_q;

   edge_det u_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.clean_in),
      .rise (rise),
      .fall (fall),
      .held (held_q)
   );

   assign timer_inc = (timer == '1) ? timer : timer + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         timer <= '0;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
      end
   end

   always_comb begin
      state_nx = state;
      timer_nx = timer_inc;
      case (state)
         S_IDLE: begin
            timer_nx = '0;
            if (rise) state_nx = S_PRESS1;
         end
         S_PRESS1: begin
            // release exactly at the long threshold is neither click nor long
            if (fall) begin
               timer_nx = '0;
               state_nx = (timer < LONG_END) ? S_WAIT2 : S_IDLE;
            end else if (timer == LONG_END) begin
               state_nx = S_LONG;
            end
         end
         S_LONG: begin
            if (fall) begin
               timer_nx = '0;
               state_nx = S_IDLE;
            end
         end
         S_WAIT2: begin
            if (rise) begin
               timer_nx = '0;
               state_nx = S_PRESS2;
            end else if (timer == DCLK_END) begin
               timer_nx = '0;
               state_nx = S_IDLE;
            end
         end
         S_PRESS2: begin
            if (fall) begin
               timer_nx = '0;
               state_nx = S_IDLE;
            end else if (timer == LONG_END) begin
               state_nx = S_LONG;
            end
         end
         default: begin
            timer_nx = '0;
            state_nx = S_IDLE;
         end
      endcase
   end

   always_comb begin
      short_nx = (state == S_WAIT2) & ~rise & (timer == DCLK_END);
      dbl_nx   = (state == S_PRESS2) & fall;
      long_nx  = ((state == S_PRESS1) | (state == S_PRESS2))
               & ~fall & (timer == LONG_END);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         dbl_q     <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         press_q   <= rise;
         release_q <= fall;
         short_q   <= short_nx;
         dbl_q     <= dbl_nx;
         long_q    <= long_nx;
      end
   end

   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;
   assign bus.short_click   = short_q;
   assign bus.double_click  = dbl_q;
   assign bus.long_press    = long_q;
   assign bus.held          = held_q;

endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 The block SHALL have parameter CNT_W, default 24, giving the width of the internal timer in bits.
REQ-002 The block SHALL have parameter LONG_CYCLES, default 24'd12_000_000, giving the number of held cycles that qualify as a long press.
REQ-003 The block SHALL have parameter DCLICK_CYCLES, default 24'd3_000_000, giving the maximum release-to-repress gap, in cycles, for a double click.
REQ-004 clk  input  1  is the single clock; all logic is on its rising edge.
REQ-005 rst  input  1  is a synchronous, active-high reset.
REQ-006 clean_in  input  1  is the debounced, clk-synchronous button level; 1 means pressed.
REQ-007 press_pulse  output  1  is a one-cycle strobe on each press edge.
REQ-008 release_pulse  output  1  is a one-cycle strobe on each release edge.
REQ-009 short_click  output  1  is a one-cycle strobe for a single click.
REQ-010 double_click  output  1  is a one-cycle strobe for a double click.
REQ-011 long_press  output  1  is a one-cycle strobe when the hold time reaches LONG_CYCLES.
REQ-012 held  output  1  is a registered copy of clean_in, delayed one cycle.

Function
REQ-013 All outputs SHALL be registered; every strobe SHALL be high for exactly one cycle, in the cycle after the clk edge that samples the qualifying condition.
REQ-014 Edge detection SHALL compare clean_in with prev, its previous registered value: rise = clean_in & ~prev, fall = ~clean_in & prev.
REQ-015 press_pulse SHALL follow every rise and release_pulse every fall, independent of FSM state.
REQ-016 FSM states SHALL be IDLE, PRESS1, LONG, WAIT2 and PRESS2.
REQ-017 IDLE: on rise, go to PRESS1 with timer cleared to 0.
REQ-018 PRESS1: timer increments each cycle while held.
- Fall with timer < LONG_CYCLES-1: go to WAIT2 with timer cleared.
- Timer reaching LONG_CYCLES-1 while still held: assert long_press and go to LONG.
REQ-019 LONG: on fall, go to IDLE; no click strobe is emitted.
REQ-020 WAIT2: timer increments each cycle.
- Rise: go to PRESS2 with timer cleared.
- Timer reaching DCLICK_CYCLES-1 with no rise: assert short_click and go to IDLE.
REQ-021 PRESS2: timer increments each cycle.
- Fall: assert double_click and go to IDLE.
- Timer reaching LONG_CYCLES-1: assert long_press and go to LONG; the first click is discarded and no short_click is emitted.
REQ-022 In WAIT2, if rise and timer expiry occur in the same cycle, rise SHALL win: go to PRESS2 and do not assert short_click.
REQ-023 The timer SHALL saturate at all-ones and never wrap.
REQ-024 LONG_CYCLES and DCLICK_CYCLES SHALL each be >= 2 and fit in CNT_W bits; the bench checks this at elaboration and fails on violation.
REQ-025 At most one of short_click, double_click and long_press SHALL be high in any cycle.

Reset
REQ-026 While rst=1, all outputs SHALL be 0, the state SHALL be IDLE and the timer SHALL be 0.
REQ-027 While rst=1, prev SHALL load clean_in, so that a button held through reset release produces no press_pulse.
REQ-028 Reset asserted mid-gesture SHALL abort the gesture; no strobe is emitted in the cycle after reset deasserts.

Structure
REQ-029 Package btn_pkg SHALL hold the FSM state encoding (3-bit localparams) and the default LONG_CYCLES, DCLICK_CYCLES and CNT_W values.
REQ-030 Sub-module edge_det SHALL produce rise and fall from clean_in; it has clk and rst ports, and its prev register follows REQ-027.
REQ-031 The FSM and the timer SHALL reside in button_events.

Verification (bench parameters: LONG_CYCLES=20, DCLICK_CYCLES=10)
REQ-032 Single click: hold clean_in high 5 cycles, then low -> press_pulse and release_pulse once each; short_click once, 10 cycles after the release edge is sampled; no other strobe.
REQ-033 Double click: high 5, low 4, high 5, low -> double_click once, in the cycle after the second fall is sampled; short_click never asserts.
REQ-034 Long press: hold high 30 cycles -> long_press once, 20 cycles after the rise is sampled; no click strobe on release.
REQ-035 Race: first release, then re-press timed so that rise coincides with the WAIT2 expiry cycle -> no short_click; the FSM enters PRESS2.
REQ-036 Reset: clean_in high through rst deassert -> no press_pulse; rst pulsed during WAIT2 -> no short_click; all outputs are 0 during rst.
REQ-037 Saturation: CNT_W=5, LONG_CYCLES=31, hold for 100 cycles -> a single long_press; the timer stays at 31.
